// File: rtl/bus_arbiter.sv
// Round-robin arbiter for eight bus requesters with a one-cycle turnaround
// between owners and an optional hold timeout that forces a release.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req_in,
  output logic [7:0] grant_out,
  output logic [2:0] select_out,
  output logic       valid_out,
  output logic       timeout_out
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_MAX = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_owner;
  logic [2:0]    r_last;
  logic [CW-1:0] r_hold;
  logic          r_timeout;

  logic          w_found;
  logic [2:0]    w_winner;

  // Round-robin search from last+1 upward; walking farthest-to-nearest lets the nearest hit win.
  always_comb begin
    w_found  = |req_in;
    w_winner = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      w_winner = req_in[r_last + i[2:0]] ? (r_last + i[2:0]) : w_winner;
    end
  end

  // Arbitration state machine with hold counter and forced-release pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= 3'd0;
      r_last    <= 3'd7;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_hold  <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!req_in[r_owner]) begin
            r_state <= ST_TURN;
          end else if ((TIMEOUT != 0) && (r_hold == HOLD_MAX)) begin
            r_state   <= ST_TURN;
            r_timeout <= 1'b1;
          end else begin
            r_hold <= r_hold + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them asynchronously.
  always_comb begin
    if (r_state == ST_GRANT) begin
      grant_out  = 8'd1 << r_owner;
      select_out = r_owner;
      valid_out  = 1'b1;
    end else begin
      grant_out  = 8'd0;
      select_out = 3'd0;
      valid_out  = 1'b0;
    end
    timeout_out = r_timeout;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues per-edge expectations,
// a monitor pops and compares them one time unit after each rising edge.
module tb_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic [7:0] req_in;
  logic [7:0] grant_out;
  logic [2:0] select_out;
  logic       valid_out;
  logic       timeout_out;

  logic [7:0] req0;
  logic [7:0] grant0;
  logic [2:0] sel0;
  logic       valid0;
  logic       to0;

  int n_tests = 0;
  int n_fail  = 0;

  string      name_q[$];
  logic [4:0] exp_q[$];

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_in(req_in),
    .grant_out(grant_out), .select_out(select_out),
    .valid_out(valid_out), .timeout_out(timeout_out)
  );

  bus_arbiter #(.TIMEOUT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_in(req0),
    .grant_out(grant0), .select_out(sel0),
    .valid_out(valid0), .timeout_out(to0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] sel, input logic v, input logic to);
    logic [7:0] g;
    g = v ? (8'd1 << sel) : 8'd0;
    n_tests++;
    if ({grant_out, select_out, valid_out, timeout_out} !== {g, sel, v, to}) begin
      n_fail++;
      $display("FAIL %s: got grant=%h sel=%0d valid=%b to=%b, expected grant=%h sel=%0d valid=%b to=%b",
               name, grant_out, select_out, valid_out, timeout_out, g, sel, v, to);
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] sel, input logic v, input logic to);
    name_q.push_back(name);
    exp_q.push_back({sel, v, to});
  endtask

  task automatic step(input string name, input logic [7:0] req, input logic [2:0] sel,
                      input logic v, input logic to);
    @(negedge clk);
    req_in = req;
    expect_out(name, sel, v, to);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_in  = 8'h00;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compare the oldest queued expectation just after every rising edge.
  always @(posedge clk) begin
    string      nm;
    logic [4:0] e;
    #1;
    if (exp_q.size() > 0) begin
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      check(nm, e[4:2], e[1], e[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v_cnt;
    int t_cnt;
    reset_n = 1'b0;
    req_in  = 8'hFF;
    req0    = 8'h00;

    // Reset held with all requests active.
    #12;
    check("reset_hold", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    expect_out("reset_first_grant", 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("reset_hold0", 8'hFF, 3'd0, 1'b1, 1'b0);
    step("reset_timeout_turn", 8'hFF, 3'd0, 1'b0, 1'b1);
    step("reset_next_owner", 8'hFF, 3'd1, 1'b1, 1'b0);

    // Round robin over requesters 2, 5, 7.
    apply_reset();
    step("rr_grant2",  8'hA4, 3'd2, 1'b1, 1'b0);
    step("rr_turn1",   8'hA0, 3'd0, 1'b0, 1'b0);
    step("rr_grant5",  8'hA4, 3'd5, 1'b1, 1'b0);
    step("rr_hold5",   8'hA4, 3'd5, 1'b1, 1'b0);
    step("rr_turn2",   8'h84, 3'd0, 1'b0, 1'b0);
    step("rr_grant7",  8'hA4, 3'd7, 1'b1, 1'b0);
    step("rr_turn3",   8'h24, 3'd0, 1'b0, 1'b0);
    step("rr_wrap2",   8'hA4, 3'd2, 1'b1, 1'b0);

    // Timeout with a single continuous requester.
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("to_hold3", 8'h08, 3'd3, 1'b1, 1'b0);
      step("to_turn", 8'h08, 3'd0, 1'b0, 1'b1);
    end
    step("to_regrant3", 8'h08, 3'd3, 1'b1, 1'b0);

    // Fairness after timeout: 0 and 4 alternate.
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("fair_hold0", 8'h11, 3'd0, 1'b1, 1'b0);
      step("fair_turn_a", 8'h11, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step("fair_hold4", 8'h11, 3'd4, 1'b1, 1'b0);
      step("fair_turn_b", 8'h11, 3'd0, 1'b0, 1'b1);
    end
    step("fair_wrap0", 8'h11, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-grant.
    apply_reset();
    step("ar_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_drop_async", 3'd0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;
    step("ar_priority0", 8'h41, 3'd0, 1'b1, 1'b0);
    step("ar_hold0",     8'h41, 3'd0, 1'b1, 1'b0);

    // Single-cycle request returns to idle.
    apply_reset();
    step("idle_grant7", 8'h80, 3'd7, 1'b1, 1'b0);
    step("idle_turn",   8'h00, 3'd0, 1'b0, 1'b0);
    step("idle_idle1",  8'h00, 3'd0, 1'b0, 1'b0);
    step("idle_idle2",  8'h00, 3'd0, 1'b0, 1'b0);

    // TIMEOUT=0 instance: long hold never times out.
    @(negedge clk);
    req0  = 8'h20;
    v_cnt = 0;
    t_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (valid0 && sel0 == 3'd5 && grant0 == 8'h20) v_cnt++;
      if (to0) t_cnt++;
    end
    req0 = 8'h00;
    n_tests++;
    if (t_cnt != 0) begin
      n_fail++;
      $display("FAIL t0_no_timeout: got %0d timeout pulses, expected 0", t_cnt);
    end
    n_tests++;
    if (v_cnt != 300) begin
      n_fail++;
      $display("FAIL t0_held: got %0d grant cycles to 5, expected 300", v_cnt);
    end

    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the common bus among eight requesters. It grants one requester at a time and drives the 3-bit bus-select code consumed by the bus source multiplexer, the same code an 8-to-3 encoder produces for the granted line. A mandatory one-cycle turnaround separates successive owners, and an optional hold timeout stops any owner from monopolising the bus.

## Interface
- `TIMEOUT`, default 15: maximum consecutive cycles a single grant may last; 0 disables the limit. Legal range is 0..255.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req_in`  input  8  request lines, one per requester; bit i is requester i.
- `grant_out`  output  8  one-hot grant, or all zeros.
- `select_out`  output  3  binary index of the granted requester; 0 when no grant.
- `valid_out`  output  1  high exactly when `grant_out` is nonzero.
- `timeout_out`  output  1  one-cycle pulse marking a forced release.

## Operation
- **States.**
  - IDLE: no grant.
  - GRANT: owner holds the bus.
  - TURN: one dead cycle with no grant.
- **Registers.**
  - `state`, `owner[2:0]`, `last[2:0]`, `hold_cnt`.
  - `hold_cnt` is `$clog2(TIMEOUT+1)` bits wide, minimum 1.
- **Selection.** Search `req_in` starting at index `(last+1) mod 8` and wrapping upward. The first asserted bit wins. The index arithmetic is 3-bit, so 7+1 wraps to 0.
- **IDLE.** If any `req_in` bit is set, load `owner` with the winner, set `last` to the winner, clear `hold_cnt`, and go to GRANT. Otherwise stay in IDLE.
- **GRANT.**
  - If `req_in[owner]` is 0, go to TURN (voluntary release).
  - Else, if `TIMEOUT != 0` and `hold_cnt == TIMEOUT-1`, go to TURN and set `timeout_out` for the TURN cycle.
  - Else, increment `hold_cnt`.
  - Requests from non-owners are ignored while in GRANT.
- **TURN.** Same selection as IDLE. With a winner, go straight to GRANT. Otherwise go to IDLE.
- **After a forced release.**
  - The former owner is `last`, so it has lowest priority in the next search.
  - If it is still the only requester, it is re-granted after TURN and `hold_cnt` restarts at 0.
- **Outputs.** All outputs are registered or decoded from registered state only; there is no combinational path from `req_in` to any output.
  - `grant_out = (state==GRANT) ? (1 << owner) : 0`.
  - `select_out = (state==GRANT) ? owner : 0`.
  - `valid_out = (state==GRANT)`.
- **Reset.**
  - On `reset_n` low, immediately and asynchronously: `state=IDLE`, `owner=0`, `last=7` (so requester 0 has first priority), `hold_cnt=0`, `timeout_out=0`.
  - Reset therefore drives `grant_out=0`, `select_out=0` and `valid_out=0`.
  - Assertion mid-grant drops the grant in the same cycle, without waiting for a clock edge.
- **Simultaneous requests.** Resolved purely by the round-robin order. Ties never occur: exactly one winner per search.

## Timing
- **Grant latency.** A request sampled at edge k in IDLE gives a grant visible after edge k; it lasts from cycle k+1 until the release edge.
- **Release.**
  - If the owner deasserts `req_in` before edge r, the grant is low after edge r (the TURN cycle).
  - The next grant appears after edge r+1.
  - The bus is therefore never granted on two consecutive cycles to different owners.
- **Timeout.** A continuously requesting owner holds the grant for exactly `TIMEOUT` cycles. The TURN cycle follows, with `timeout_out=1` for that one cycle only.
- **Re-grant.** The minimum gap between two grants to the same requester is one cycle (TURN).
- **Requests during TURN.** A request that appears during TURN is sampled at the TURN-exiting edge.
- **Throughput.** Eight continuous requesters are served in order 0..7 and then wrap to 0. With `TIMEOUT=15`, each gets 15 cycles plus 1 turnaround.
- **Glitches.** `req_in` glitches between edges have no effect.

## Test plan
- **Reset.** Drive `reset_n=0` with `req_in=8'hFF`, then release it at a known edge.
  - During reset, all outputs must be 0.
  - After the first edge, `select_out=0`, `grant_out=8'h01` and `valid_out=1`.
- **Round robin.** Hold `req_in=8'b1010_0100` and release each owner by dropping its bit for one cycle.
  - Grant order must be 2, 5, 7, 2.
  - Each handover must contain exactly one cycle with `valid_out=0`.
- **Timeout.** With `TIMEOUT=4`, hold `req_in=8'h08` continuously.
  - Required waveform: `select_out=3` and `valid_out=1` for 4 cycles, then 1 cycle with `valid_out=0` and `timeout_out=1`, then re-grant to 3.
  - The pattern must repeat.
- **Fairness after timeout.** With `TIMEOUT=4` and `req_in=8'h11`, the grants must alternate 0, 4, 0, 4, each lasting 4 cycles with a 1-cycle TURN between them.
- **Async reset mid-grant.** Pulse `reset_n` low mid-cycle while requester 6 owns the bus.
  - `grant_out` must drop to 0 before the next edge.
  - After release, priority restarts at requester 0.
- **Idle return and TIMEOUT=0.**
  - A single 1-cycle request `8'h80` gives 1 grant cycle to 7, then TURN, then IDLE with all outputs 0.
  - With `TIMEOUT=0`, a 300-cycle hold produces no `timeout_out`.
